// File: rtl/matrix_multiplier_v3.sv
// matrix_multiplier_v3: pipelined signed fixed-point Z = X * Y over external synchronous RAMs
// Ports: clk, rst (async, active-high), start; x_rows/y_cols/x_cols_y_rows dims; x_base/y_base/z_base
// row-major base addresses; x_data/y_data signed RAM read data; x_addr/y_addr/z_addr registered
// addresses; z_data registered result, z_wen write strobe; busy, done.
// Optional MM_SATURATE_EN: clamp results to DATA_WIDTH and add sticky sat_flag output.
module matrix_multiplier_v3 #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ACC_WIDTH   = 64,
  parameter int RAM_LATENCY = 1,
  parameter int FRAC_BITS   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        x_rows,
  input  logic [ADDR_WIDTH-1:0]        y_cols,
  input  logic [ADDR_WIDTH-1:0]        x_cols_y_rows,
  input  logic [ADDR_WIDTH-1:0]        x_base,
  input  logic [ADDR_WIDTH-1:0]        y_base,
  input  logic [ADDR_WIDTH-1:0]        z_base,
  input  logic signed [DATA_WIDTH-1:0] x_data,
  input  logic signed [DATA_WIDTH-1:0] y_data,
  output logic [ADDR_WIDTH-1:0]        x_addr,
  output logic [ADDR_WIDTH-1:0]        y_addr,
  output logic [ADDR_WIDTH-1:0]        z_addr,
  output logic [DATA_WIDTH-1:0]        z_data,
  output logic                         z_wen,
  output logic                         busy,
  output logic                         done
`ifdef MM_SATURATE_EN
  , output logic                       sat_flag
`endif
);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] rows_q, cols_q, inner_q, ybase_q, x_row, y_col, r, c, cnt, last_k;
  logic [RAM_LATENCY-1:0] vp;
  logic signed [ACC_WIDTH-1:0] xs, ys, acc, acc_nx;
  logic [DATA_WIDTH-1:0] z_nx;
  logic issue, last_el, last_c;
  assign last_k  = inner_q == '0 ? '0 : inner_q - 1'b1;
  assign last_c  = c == cols_q - 1'b1;
  assign last_el = last_c && r == rows_q - 1'b1;
  assign issue   = state_q == ISSUE && inner_q != '0;
  assign xs      = ACC_WIDTH'(x_data);
  assign ys      = ACC_WIDTH'(y_data);
  // Products arrive RAM_LATENCY cycles after their issue, tracked by the valid pipe.
  assign acc_nx  = vp[RAM_LATENCY-1] ? acc + xs * ys : acc;
`ifdef MM_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic sat_hi, sat_lo;
  assign shifted = acc_nx >>> FRAC_BITS;
  assign sat_hi  = shifted > SAT_MAX;
  assign sat_lo  = shifted < SAT_MIN;
  assign z_nx    = sat_hi ? SAT_MAX[DATA_WIDTH-1:0] : sat_lo ? SAT_MIN[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
`else
  assign z_nx    = DATA_WIDTH'(acc_nx >>> FRAC_BITS);
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (x_rows == '0 || y_cols == '0) ? DONE : ISSUE;
      ISSUE:   if (cnt == last_k) state_d = DRAIN;
      DRAIN:   if (cnt == ADDR_WIDTH'(RAM_LATENCY - 1)) state_d = WRITE;
      WRITE:   state_d = last_el ? DONE : ISSUE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy  = state_q != IDLE;
    done  = state_q == DONE;
    z_wen = state_q == WRITE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_q  <= '0;
      cols_q  <= '0;
      inner_q <= '0;
      ybase_q <= '0;
      x_row   <= '0;
      y_col   <= '0;
      r       <= '0;
      c       <= '0;
      cnt     <= '0;
      vp      <= '0;
      acc     <= '0;
      x_addr  <= '0;
      y_addr  <= '0;
      z_addr  <= '0;
      z_data  <= '0;
`ifdef MM_SATURATE_EN
      sat_flag <= 1'b0;
`endif
    end else begin
      cnt <= state_d != state_q ? '0 : cnt + 1'b1;
      vp  <= (vp << 1) | RAM_LATENCY'(issue);
      acc <= (state_q == ISSUE && cnt == '0) ? '0 : acc_nx;
      if (state_q == IDLE && start) begin
        rows_q  <= x_rows;
        cols_q  <= y_cols;
        inner_q <= x_cols_y_rows;
        ybase_q <= y_base;
        x_row   <= x_base;
        y_col   <= y_base;
        r       <= '0;
        c       <= '0;
        x_addr  <= x_base;
        y_addr  <= y_base;
        z_addr  <= z_base;
`ifdef MM_SATURATE_EN
        sat_flag <= 1'b0;
`endif
      end
      if (state_q == ISSUE) begin
        x_addr <= x_addr + 1'b1;
        y_addr <= y_addr + cols_q;
      end
      if (state_q == DRAIN && state_d == WRITE) begin
        z_data <= z_nx;
`ifdef MM_SATURATE_EN
        sat_flag <= sat_flag | sat_hi | sat_lo;
`endif
      end
      // Next element start addresses come from running row/column bases, not multiplies.
      if (state_q == WRITE && !last_el) begin
        z_addr <= z_addr + 1'b1;
        c      <= last_c ? '0 : c + 1'b1;
        r      <= last_c ? r + 1'b1 : r;
        x_row  <= last_c ? x_row + inner_q : x_row;
        y_col  <= last_c ? ybase_q : y_col + 1'b1;
        x_addr <= last_c ? x_row + inner_q : x_row;
        y_addr <= last_c ? ybase_q : y_col + 1'b1;
      end
    end
  end
endmodule
